// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional feature macro used by this slice: DMEM_ADDR_CHECK_EN.
package dmem_pkg;

    typedef enum logic [0:0] {
        P0_PRI = 1'b0,
        P1_PRI = 1'b1
    } arb_state_t;

    localparam logic [5:0] LOAD_OP    = 6'b110000;
    localparam logic [5:0] STORE_OP   = 6'b110001;
    localparam int         DMEM_DEPTH = 1024;
    localparam int         DMEM_AW    = 10;
    localparam int         DMEM_DW    = 32;

    // Out-of-range upper bits or a non-word-aligned byte address.
    function automatic logic addr_illegal(input logic [31:0] addr);
        return (|addr[31:DMEM_AW+2]) | (|addr[1:0]);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle of the data-memory arbiter.
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic               p0_req;
    logic               p0_we;
    logic [31:0]        p0_addr;
    logic [DMEM_DW-1:0] p0_wdata;
    logic               p0_gnt;
    logic               p0_rvalid;
    logic [DMEM_DW-1:0] p0_rdata;
    logic               p0_err;

    logic               p1_req;
    logic               p1_we;
    logic [31:0]        p1_addr;
    logic [DMEM_DW-1:0] p1_wdata;
    logic               p1_gnt;
    logic               p1_rvalid;
    logic [DMEM_DW-1:0] p1_rdata;
    logic               p1_err;

    logic               stall_mem;
    logic               mem_en;
    logic               mem_we;
    logic [DMEM_AW-1:0] mem_addr;
    logic [DMEM_DW-1:0] mem_wdata;
    logic [DMEM_DW-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output stall_mem, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  stall_mem, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_resp_pipe.sv
// One-cycle response stage for a single port: rvalid/err flags and the
// read-data forward from the registered memory output.
module dmem_resp_pipe
    import dmem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_err,
    input  logic [DMEM_DW-1:0] i_mem_rdata,
    output logic               o_rvalid,
    output logic               o_err,
    output logic [DMEM_DW-1:0] o_rdata
);

    logic r_rvalid;
    logic r_err;
    logic r_fwd;

    // Capture this cycle's grant outcome for presentation next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_fwd    <= 1'b0;
        end else begin
            r_rvalid <= i_load;
            r_err    <= i_err;
            r_fwd    <= i_load & ~i_err;
        end
    end

    // Memory data is already registered; only a real load forwards it.
    assign o_rdata  = r_fwd ? i_mem_rdata : {DMEM_DW{1'b0}};
    assign o_rvalid = r_rvalid;
    assign o_err    = r_err;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported data memory: fixed port-0 priority
// bounded by a port-1 starvation counter. Optional: DMEM_ADDR_CHECK_EN.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH    = DMEM_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int DW       = DMEM_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [3:0]    r_wait_cnt;
    logic [3:0]    w_cnt_nxt;
    logic          w_p0_win;
    logic          w_p1_win;
    logic          w_p0_gnt;
    logic          w_p1_gnt;
    logic          w_p0_bad;
    logic          w_p1_bad;
    logic          w_mem_en;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;

`ifdef DMEM_ADDR_CHECK_EN
    assign w_p0_bad = addr_illegal(bus.p0_addr);
    assign w_p1_bad = addr_illegal(bus.p1_addr);
`else
    assign w_p0_bad = 1'b0;
    assign w_p1_bad = 1'b0;
    wire w_unused_addr = ^{bus.p0_addr[31:AW+2], bus.p0_addr[1:0],
                           bus.p1_addr[31:AW+2], bus.p1_addr[1:0]};
`endif

    // Grant decision; port 1 wins a conflict only while it holds priority.
    always_comb begin
        w_p1_win = bus.p1_req & (~bus.p0_req | (r_state == P1_PRI));
        w_p0_win = bus.p0_req & ~w_p1_win;
        w_p0_gnt = w_p0_win & rst_n;
        w_p1_gnt = w_p1_win & rst_n;
    end

    // Steer the winner onto the memory bus; illegal addresses never reach it.
    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = {AW{1'b0}};
        w_mem_wdata = {DW{1'b0}};
        if (w_p1_gnt && !w_p1_bad) begin
            w_mem_en    = 1'b1;
            w_mem_we    = bus.p1_we;
            w_mem_addr  = bus.p1_addr[AW+1:2];
            w_mem_wdata = bus.p1_wdata;
        end else if (w_p0_gnt && !w_p0_bad) begin
            w_mem_en    = 1'b1;
            w_mem_we    = bus.p0_we;
            w_mem_addr  = bus.p0_addr[AW+1:2];
            w_mem_wdata = bus.p0_wdata;
        end else begin
            w_mem_en    = 1'b0;
        end
    end

    // Priority FSM next state and port-1 starvation counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        if (w_p1_gnt) begin
            w_state_nxt = P0_PRI;
            w_cnt_nxt   = 4'd0;
        end else begin
            case (r_state)
                P0_PRI: begin
                    if (bus.p1_req) begin
                        if (r_wait_cnt < MAX_CNT) begin
                            w_cnt_nxt = r_wait_cnt + 4'd1;
                        end else begin
                            w_cnt_nxt = MAX_CNT;
                        end
                        if (w_cnt_nxt == MAX_CNT) begin
                            w_state_nxt = P1_PRI;
                        end else begin
                            w_state_nxt = P0_PRI;
                        end
                    end else begin
                        w_state_nxt = P0_PRI;
                    end
                end
                P1_PRI: begin
                    if (!bus.p1_req) begin
                        w_state_nxt = P0_PRI;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = P1_PRI;
                    end
                end
                default: begin
                    w_state_nxt = P0_PRI;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= P0_PRI;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_cnt_nxt;
        end
    end

    dmem_resp_pipe u_resp0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_p0_gnt & ~bus.p0_we),
        .i_err       (w_p0_gnt & w_p0_bad),
        .i_mem_rdata (bus.mem_rdata),
        .o_rvalid    (bus.p0_rvalid),
        .o_err       (bus.p0_err),
        .o_rdata     (bus.p0_rdata)
    );

    dmem_resp_pipe u_resp1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_p1_gnt & ~bus.p1_we),
        .i_err       (w_p1_gnt & w_p1_bad),
        .i_mem_rdata (bus.mem_rdata),
        .o_rvalid    (bus.p1_rvalid),
        .o_err       (bus.p1_err),
        .o_rdata     (bus.p1_rdata)
    );

    assign bus.p0_gnt    = w_p0_gnt;
    assign bus.p1_gnt    = w_p1_gnt;
    assign bus.stall_mem = bus.p0_req & ~w_p0_gnt & rst_n;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with a behavioural 1024x32 memory.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem [0:1023];
    int          n_vec;
    int          n_bad;

    dmem_arbiter_if bus();

    dmem_arbiter #(.MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic test_reset;
        bus.p0_req = 1'b1; bus.p1_req = 1'b1;
        #1;
        n_vec++; if (bus.p0_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_p0_gnt got %h want 0", bus.p0_gnt); end
        n_vec++; if (bus.p1_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_p1_gnt got %h want 0", bus.p1_gnt); end
        n_vec++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en got %h want 0", bus.mem_en); end
        n_vec++; if (bus.stall_mem !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %h want 0", bus.stall_mem); end
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_vec++; if ({bus.p0_rvalid, bus.p1_rvalid, bus.p0_err, bus.p1_err} !== 4'b0000) begin n_bad++; $display("FAIL rst_resp got %b want 0000", {bus.p0_rvalid, bus.p1_rvalid, bus.p0_err, bus.p1_err}); end
        tick();
    endtask

    task automatic test_lone_load;
        bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h0000_0fe4;
        #1;
        n_vec++; if (bus.p0_gnt !== 1'b1) begin n_bad++; $display("FAIL lone_gnt got %h want 1", bus.p0_gnt); end
        n_vec++; if (bus.mem_addr !== 10'h3f9) begin n_bad++; $display("FAIL lone_addr got %h want 3f9", bus.mem_addr); end
        n_vec++; if ({bus.mem_en, bus.mem_we} !== 2'b10) begin n_bad++; $display("FAIL lone_en_we got %b want 10", {bus.mem_en, bus.mem_we}); end
        n_vec++; if (bus.stall_mem !== 1'b0) begin n_bad++; $display("FAIL lone_stall got %h want 0", bus.stall_mem); end
        tick();
        bus.p0_req = 1'b0;
        #1;
        n_vec++; if (bus.p0_rvalid !== 1'b1) begin n_bad++; $display("FAIL lone_rvalid got %h want 1", bus.p0_rvalid); end
        n_vec++; if (bus.p0_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL lone_rdata got %h want 12345678", bus.p0_rdata); end
        tick();
        n_vec++; if ({bus.p0_rvalid, bus.p0_rdata} !== 33'd0) begin n_bad++; $display("FAIL lone_after got %h/%h want 0/0", bus.p0_rvalid, bus.p0_rdata); end
    endtask

    task automatic test_store_load;
        bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'h0000_00f0; bus.p0_wdata = 32'hAA98_BFEA;
        #1;
        n_vec++; if ({bus.p0_gnt, bus.mem_en, bus.mem_we} !== 3'b111) begin n_bad++; $display("FAIL st_gnt_en_we got %b want 111", {bus.p0_gnt, bus.mem_en, bus.mem_we}); end
        n_vec++; if (bus.mem_addr !== 10'h03c) begin n_bad++; $display("FAIL st_addr got %h want 03c", bus.mem_addr); end
        n_vec++; if (bus.mem_wdata !== 32'hAA98_BFEA) begin n_bad++; $display("FAIL st_wdata got %h want aa98bfea", bus.mem_wdata); end
        tick();
        bus.p0_we = 1'b0;
        #1;
        n_vec++; if (bus.p0_rvalid !== 1'b0) begin n_bad++; $display("FAIL st_no_rvalid got %h want 0", bus.p0_rvalid); end
        n_vec++; if ({bus.p0_gnt, bus.mem_we} !== 2'b10) begin n_bad++; $display("FAIL ld_gnt_we got %b want 10", {bus.p0_gnt, bus.mem_we}); end
        tick();
        bus.p0_req = 1'b0;
        #1;
        n_vec++; if (bus.p0_rdata !== 32'hAA98_BFEA || bus.p0_rvalid !== 1'b1) begin n_bad++; $display("FAIL ld_rdata got %h/%h want 1/aa98bfea", bus.p0_rvalid, bus.p0_rdata); end
        tick();
    endtask

    task automatic test_starvation;
        logic exp_p1;
        logic exp_p0;
        logic exp_rv0;
        bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h0000_0100;
        bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h0000_0200;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) begin bus.p0_req = 1'b0; bus.p1_req = 1'b0; end
            #1;
            exp_p1 = (c == 4);
            exp_p0 = (c < 6) && !exp_p1;
            n_vec++; if (bus.p0_gnt !== exp_p0) begin n_bad++; $display("FAIL starve_p0_gnt c%0d got %h want %h", c, bus.p0_gnt, exp_p0); end
            n_vec++; if (bus.p1_gnt !== exp_p1) begin n_bad++; $display("FAIL starve_p1_gnt c%0d got %h want %h", c, bus.p1_gnt, exp_p1); end
            n_vec++; if (bus.stall_mem !== exp_p1) begin n_bad++; $display("FAIL starve_stall c%0d got %h want %h", c, bus.stall_mem, exp_p1); end
            if (c < 6) begin
                n_vec++; if (bus.mem_addr !== (exp_p1 ? 10'h080 : 10'h040)) begin n_bad++; $display("FAIL starve_addr c%0d got %h want %h", c, bus.mem_addr, exp_p1 ? 10'h080 : 10'h040); end
            end
            if (c >= 1) begin
                exp_rv0 = (c != 5);
                n_vec++; if (bus.p0_rvalid !== exp_rv0) begin n_bad++; $display("FAIL b2b_rvalid0 c%0d got %h want %h", c, bus.p0_rvalid, exp_rv0); end
                n_vec++; if (bus.p0_rdata !== (exp_rv0 ? 32'h0BAD_BEEF : 32'h0)) begin n_bad++; $display("FAIL b2b_rdata0 c%0d got %h", c, bus.p0_rdata); end
                n_vec++; if (bus.p1_rvalid !== (c == 5)) begin n_bad++; $display("FAIL starve_rvalid1 c%0d got %h want %h", c, bus.p1_rvalid, (c == 5)); end
                n_vec++; if (bus.p1_rdata !== ((c == 5) ? 32'hCAFE_F00D : 32'h0)) begin n_bad++; $display("FAIL starve_rdata1 c%0d got %h", c, bus.p1_rdata); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 32'h0;
        #1;
        n_vec++; if (bus.p1_gnt !== 1'b1) begin n_bad++; $display("FAIL midrst_gnt got %h want 1", bus.p1_gnt); end
        tick();
        rst_n = 1'b0; bus.p0_req = 1'b1;
        #1;
        n_vec++; if ({bus.p0_gnt, bus.p1_gnt, bus.mem_en, bus.stall_mem} !== 4'b0000) begin n_bad++; $display("FAIL midrst_outs got %b want 0000", {bus.p0_gnt, bus.p1_gnt, bus.mem_en, bus.stall_mem}); end
        n_vec++; if (bus.p1_rvalid !== 1'b0) begin n_bad++; $display("FAIL midrst_rvalid got %h want 0", bus.p1_rvalid); end
        tick();
        bus.p0_req = 1'b0; bus.p1_req = 1'b0; rst_n = 1'b1;
        tick();
        n_vec++; if (bus.p1_rvalid !== 1'b0) begin n_bad++; $display("FAIL midrst_post got %h want 0", bus.p1_rvalid); end
        bus.p0_req = 1'b1; bus.p1_req = 1'b1;
        #1;
        n_vec++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b10) begin n_bad++; $display("FAIL midrst_pri got %b want 10", {bus.p0_gnt, bus.p1_gnt}); end
        tick();
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        tick();
    endtask

    task automatic test_addr_check;
        bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h0001_0000;
        #1;
        n_vec++; if (bus.p0_gnt !== 1'b1) begin n_bad++; $display("FAIL ac_gnt got %h want 1", bus.p0_gnt); end
`ifdef DMEM_ADDR_CHECK_EN
        n_vec++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL ac_mem_en got %h want 0", bus.mem_en); end
        tick();
        bus.p0_req = 1'b0;
        #1;
        n_vec++; if ({bus.p0_err, bus.p0_rvalid} !== 2'b11) begin n_bad++; $display("FAIL ac_err_rvalid got %b want 11", {bus.p0_err, bus.p0_rvalid}); end
        n_vec++; if (bus.p0_rdata !== 32'h0) begin n_bad++; $display("FAIL ac_rdata got %h want 0", bus.p0_rdata); end
`else
        n_vec++; if ({bus.mem_en, bus.mem_addr} !== {1'b1, 10'h000}) begin n_bad++; $display("FAIL ac_wrap got %h/%h want 1/000", bus.mem_en, bus.mem_addr); end
        tick();
        bus.p0_req = 1'b0;
        #1;
        n_vec++; if ({bus.p0_err, bus.p0_rvalid} !== 2'b01) begin n_bad++; $display("FAIL ac_err_rvalid got %b want 01", {bus.p0_err, bus.p0_rvalid}); end
        n_vec++; if (bus.p0_rdata !== 32'h55AA_1234) begin n_bad++; $display("FAIL ac_rdata got %h want 55aa1234", bus.p0_rdata); end
`endif
        tick();
    endtask

    task automatic test_alternating;
        logic        t_we [4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] t_addr [4] = '{32'h0, 32'h4, 32'h4, 32'h0};
        logic [31:0] t_wd [4]   = '{32'h0, 32'h1111_2222, 32'h0, 32'h3333_4444};
        logic [31:0] t_rd [5]   = '{32'h0, 32'h55AA_1234, 32'h0, 32'h1111_2222, 32'h0};
        logic        exp_rv;
        for (int c = 0; c < 5; c++) begin
            if (c < 4) begin
                bus.p1_req = 1'b1; bus.p1_we = t_we[c]; bus.p1_addr = t_addr[c]; bus.p1_wdata = t_wd[c];
            end else begin
                bus.p1_req = 1'b0;
            end
            #1;
            exp_rv = (c == 1) || (c == 3);
            n_vec++; if (bus.p1_gnt !== (c < 4)) begin n_bad++; $display("FAIL alt_gnt c%0d got %h want %h", c, bus.p1_gnt, (c < 4)); end
            n_vec++; if (bus.mem_we !== ((c < 4) && t_we[c % 4])) begin n_bad++; $display("FAIL alt_we c%0d got %h", c, bus.mem_we); end
            n_vec++; if (bus.p1_rvalid !== exp_rv) begin n_bad++; $display("FAIL alt_rvalid c%0d got %h want %h", c, bus.p1_rvalid, exp_rv); end
            n_vec++; if (bus.p1_rdata !== t_rd[c]) begin n_bad++; $display("FAIL alt_rdata c%0d got %h want %h", c, bus.p1_rdata, t_rd[c]); end
            tick();
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; n_vec = 0; n_bad = 0;
        pre_we = 1'b0; pre_addr = 10'h0; pre_data = 32'h0;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 32'h0; bus.p0_wdata = 32'h0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 32'h0; bus.p1_wdata = 32'h0;
        bus.mem_rdata = 32'h0;
        preload(10'h3f9, 32'h1234_5678);
        preload(10'h040, 32'h0BAD_BEEF);
        preload(10'h080, 32'hCAFE_F00D);
        preload(10'h000, 32'h55AA_1234);
        test_reset();
        test_lone_load();
        test_store_load();
        test_starvation();
        test_reset_mid();
        test_addr_check();
        test_alternating();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-ported 1024x32 data memory between two requesters. Port 0 is the pipeline MEM stage (load/store datapath); port 1 is a secondary master (DMA/loader/debug).
The block issues the memory access, arbitrates conflicts with a starvation-bounded fixed priority, and returns read data one cycle after grant.
It generates the MEM-stage stall when port 0 loses arbitration.

Parameters:
DEPTH, 1024, data memory depth in 32-bit words
AW, 10, word-address width (log2 DEPTH)
DW, 32, data width
MAX_WAIT, 4, consecutive port-1 denials before port 1 is forced to priority (range 1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
p0_req  in  1  MEM-stage access request
p0_we  in  1  1 = store, 0 = load
p0_addr  in  32  byte address (word index = addr[AW+1:2])
p0_wdata  in  DW  store data
p0_gnt  out  1  access issued this cycle (combinational)
p0_rvalid  out  1  load data valid
p0_rdata  out  DW  load data
p0_err  out  1  address error response
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as port 0, for port 1
stall_mem  out  1  p0_req & ~p0_gnt
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory word address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, registered, valid one cycle after mem_en & ~mem_we

Behaviour:
- Reset (rst_n low, async): state=P0_PRI, wait_cnt=0, all rvalid/err regs 0. While rst_n is low, gnt/mem_en/mem_we/stall_mem are forced to 0.
- Handshake: a requester holds req, we, addr and wdata stable until it sees gnt high at a rising edge. One grant per cycle maximum.
- Grant decision is combinational each cycle. A lone requester is always granted.
- Conflict while in P0_PRI: port 0 wins. Conflict while in P1_PRI: port 1 wins.
- mem_* outputs mirror the winning port's request: mem_en=1, mem_we=we, mem_addr=addr[AW+1:2], mem_wdata=wdata. With no winner, mem_en=0 and the other mem_* outputs are 0.
- Read latency: a granted load in cycle N gives that port rvalid=1 in cycle N+1 for exactly one cycle. rdata=mem_rdata in that cycle; rdata=0 otherwise.
- Stores produce no rvalid. Their completion is the gnt itself.
- FSM and counter:
  - In P0_PRI, a cycle with p1_req & ~p1_gnt increments wait_cnt (saturating at MAX_WAIT).
  - When wait_cnt reaches MAX_WAIT, the next state is P1_PRI.
  - Any p1_gnt clears wait_cnt and returns the FSM to P0_PRI.
  - In P1_PRI without p1_req, the FSM returns to P0_PRI and wait_cnt clears.
- Port 1 is therefore granted within MAX_WAIT+1 cycles under continuous port-0 traffic.
- stall_mem is asserted exactly on cycles where p0_req=1 and p0_gnt=0.
- Reset asserted mid-access: pending rvalid/err is dropped and no response is produced after reset.
- Back-to-back reads from the same port give rvalid on consecutive cycles.

Optional Feature:
DMEM_ADDR_CHECK_EN:
- Defined: a request with any nonzero addr[31:AW+2] or addr[1:0] is still arbitrated and granted, but mem_en stays 0. In the next cycle that port gets err=1 for one cycle (plus rvalid=1 with rdata=0 if the request was a load).
- Undefined: err outputs are tied 0, upper and lower address bits are ignored, and addresses wrap modulo DEPTH.

Decomposition:
Shared package dmem_pkg holds:
- the arb_state_t enum (P0_PRI, P1_PRI)
- localparams LOAD_OP=6'b110000 and STORE_OP=6'b110001
- DMEM_DEPTH=1024 and DMEM_AW=10

One natural sub-module, dmem_resp_pipe: the per-port one-cycle rvalid/err/rdata response register, instantiated twice.

Test Plan:
- p0 load addr 0x00000fe4 alone (mem[0x3f9]=0x12345678) -> p0_gnt=1 same cycle, mem_addr=0x3f9, p0_rvalid=1 with rdata=0x12345678 next cycle, stall_mem=0.
- p0 store addr 0x000000f0, wdata 0xAA98BFEA, then p0 load same addr -> mem_we=1 on cycle 1, load returns 0xAA98BFEA.
- p0 and p1 both requesting continuously, MAX_WAIT=4 -> p0 granted cycles 0-3, p1 granted cycle 4, wait_cnt back to 0, p0 granted cycle 5, stall_mem=1 only in cycle 4.
- p1 load granted, rst_n pulled low in the following cycle -> p1_rvalid stays 0, gnt/mem_en drop immediately, state=P0_PRI after release.
- DMEM_ADDR_CHECK_EN defined, p0 load addr 0x00010000 -> p0_gnt=1, mem_en=0, next cycle p0_err=1, p0_rvalid=1, rdata=0. Macro undefined -> mem_addr=0x000, normal read.
- Alternating p1 read/write at addresses 0x0,0x4 with p0 idle -> p1 granted every cycle, rvalid only after the reads.
